// File: rtl/serial_add_controller.sv
// Purpose: word-level front/back end for a bit-serial adder (parallel operands in, LSB-first bits out, parallel sum back).
// Latency: accept at edge E, out_valid high in the cycle after edge E+WIDTH+1; one word in flight, issue interval >= WIDTH+3.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready, and in_ready stays low until the cycle after that handshake.
module serial_add_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             ser_clr,
  output logic             ser_en,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_cin,
  input  logic             ser_s,
  input  logic             ser_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  // Counter wide enough to index WIDTH bits; a 1-bit word still needs a 1-bit counter.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cin_q, cin_d;
  logic             in_ready_q, in_ready_d;
  logic             ser_clr_q, ser_clr_d;
  logic             ser_en_q, ser_en_d;
  logic             ser_a_q, ser_a_d;
  logic             ser_b_q, ser_b_d;
  logic             ser_cin_q, ser_cin_d;
  logic             out_valid_q, out_valid_d;
  logic             out_cout_q, out_cout_d;

  logic accept;
  logic last_bit;

  assign accept   = in_valid && in_ready_q && (state_q == IDLE);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Next-state logic; every registered output is derived from the state being entered so it lines up with that state.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    cin_d      = cin_q;
    out_cout_d = out_cout_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          cnt_d   = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        // Sum bits arrive LSB first, so they enter at the MSB and walk down.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = ser_s;
        cnt_d            = cnt_q + 1'b1;
        if (last_bit) begin
          out_cout_d = ser_cout;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    ser_clr_d   = (state_d == CLR);
    ser_en_d    = (state_d == SHIFT);
    out_valid_d = (state_d == DONE);
    ser_a_d     = 1'b0;
    ser_b_d     = 1'b0;
    ser_cin_d   = 1'b0;

    // Load the next bit slot: operand LSBs go out and the operands shift right.
    // The word carry-in is only driven in the first slot (entered straight from CLR).
    if (state_d == SHIFT) begin
      ser_a_d   = a_q[0];
      ser_b_d   = b_q[0];
      ser_cin_d = cin_q && (state_q == CLR);
      a_d       = a_q >> 1;
      b_d       = b_q >> 1;
    end
  end

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      cin_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      ser_clr_q   <= 1'b0;
      ser_en_q    <= 1'b0;
      ser_a_q     <= 1'b0;
      ser_b_q     <= 1'b0;
      ser_cin_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      cin_q       <= cin_d;
      in_ready_q  <= in_ready_d;
      ser_clr_q   <= ser_clr_d;
      ser_en_q    <= ser_en_d;
      ser_a_q     <= ser_a_d;
      ser_b_q     <= ser_b_d;
      ser_cin_q   <= ser_cin_d;
      out_valid_q <= out_valid_d;
      out_cout_q  <= out_cout_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign ser_clr   = ser_clr_q;
  assign ser_en    = ser_en_q;
  assign ser_a     = ser_a_q;
  assign ser_b     = ser_b_q;
  assign ser_cin   = ser_cin_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = out_cout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_add_controller.sv
// Bench for serial_add_controller with a behavioural bit-serial adder attached.
// Expected results are hand-computed constants queued at issue and popped by a result monitor.
module tb_serial_add_controller;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         ser_clr;
  logic         ser_en;
  logic         ser_a;
  logic         ser_b;
  logic         ser_cin;
  logic         ser_s;
  logic         ser_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  serial_add_controller #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .ser_clr   (ser_clr),
    .ser_en    (ser_en),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_cin   (ser_cin),
    .ser_s     (ser_s),
    .ser_cout  (ser_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  // Behavioural serial adder: combinational sum/carry, carry register cleared by ser_clr.
  logic carry_q;
  logic cin_eff;
  assign cin_eff  = carry_q | ser_cin;
  assign ser_s    = ser_a ^ ser_b ^ cin_eff;
  assign ser_cout = (ser_a & ser_b) | (ser_a & cin_eff) | (ser_b & cin_eff);

  always @(posedge clk or negedge reset) begin
    if (!reset)       carry_q <= 1'b0;
    else if (ser_clr) carry_q <= 1'b0;
    else if (ser_en)  carry_q <= ser_cout;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of {cout, sum}.
  logic [W:0] sb[$];
  int hs_cyc  = 0;
  int hs_cnt  = 0;
  int acc_cyc = 0;

  // Result monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'({out_cout, out_sum}), 64'h1ff);
      end else begin
        check("result", 64'({out_cout, out_sum}), 64'(sb.pop_front()));
      end
      hs_cyc = cyc;
      hs_cnt++;
    end
  end

  // Accept monitor.
  always @(negedge clk) begin
    if (reset && in_valid && in_ready) acc_cyc = cyc;
  end

  // Serial stream capture and idle-zero check on the ser_* bits.
  logic [W-1:0] a_cap, b_cap, cin_cap;
  int en_cnt  = 0;
  int clr_cnt = 0;
  always @(negedge clk) begin
    if (ser_clr) clr_cnt++;
    if (ser_en) begin
      if (en_cnt < W) begin
        a_cap[en_cnt[2:0]]   = ser_a;
        b_cap[en_cnt[2:0]]   = ser_b;
        cin_cap[en_cnt[2:0]] = ser_cin;
      end
      en_cnt++;
    end else begin
      check("ser_idle_zero", 64'({ser_a, ser_b, ser_cin}), 64'h0);
    end
  end

  function automatic logic [63:0] all_outs();
    return 64'({in_ready, ser_clr, ser_en, ser_a, ser_b, ser_cin, out_valid, out_cout, busy, out_sum});
  endfunction

  // Present a word and hold in_valid until it is accepted; returns at accept edge + 1.
  task automatic accept_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                             input logic [W-1:0] exp_sum, input logic exp_cout);
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      check("accept_timeout", 64'h0, 64'h1);
      in_valid = 1'b0;
    end else begin
      sb.push_back({exp_cout, exp_sum});
      @(posedge clk); #1;
      in_valid = 1'b0;
      en_cnt   = 0;
      clr_cnt  = 0;
    end
  endtask

  // Wait for out_valid (called at accept edge + 1) and check latency and serial stream.
  task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int  n;
    bit  got;
    logic [W-1:0] cin_exp;
    n   = 0;
    got = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n   = i;
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      check("result_timeout", 64'h0, 64'h1);
    end else begin
      cin_exp = '0;
      cin_exp[0] = c;
      check("latency", 64'(n), 64'(W + 2));
      check("ser_a_seq", 64'(a_cap), 64'(a));
      check("ser_b_seq", 64'(b_cap), 64'(b));
      check("ser_cin_seq", 64'(cin_cap), 64'(cin_exp));
      check("ser_en_slots", 64'(en_cnt), 64'(W));
      check("ser_clr_pulses", 64'(clr_cnt), 64'h1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs_before;
    bit seen;

    // Reset held with in_valid high.
    reset = 1'b0; in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A; in_cin = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", all_outs(), 64'h0);
    end
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_before_edge", 64'(in_ready), 64'h0);
    @(negedge clk);
    check("in_ready_after_release", 64'(in_ready), 64'h1);
    check("no_ser_en_after_reset", 64'({ser_en, ser_clr, busy}), 64'h0);

    // Basic word and carry ripple cases.
    accept_word(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    wait_result(8'h5A, 8'h3C, 1'b0);
    accept_word(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    wait_result(8'hFF, 8'h01, 1'b0);
    accept_word(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    wait_result(8'hFF, 8'hFF, 1'b1);

    // Backpressure: result held, stray in_valid ignored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    accept_word(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    wait_result(8'h12, 8'h34, 1'b0);
    hs_before = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        in_a = 8'h11; in_b = 8'h22; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_hold", 64'({out_valid, in_ready, out_cout, out_sum}), 64'({1'b1, 1'b0, 1'b0, 8'h46}));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_one_handshake", 64'(hs_cnt - hs_before), 64'h1);
    check("bp_idle_after", 64'({out_valid, busy, in_ready}), 64'h1);
    check("bp_no_new_clr", 64'(clr_cnt), 64'h1);

    // Reset during SHIFT bit 3.
    accept_word(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_abort_bit3", 64'({ser_en, 8'(en_cnt)}), 64'({1'b1, 8'd3}));
    reset = 1'b0;
    sb.delete();
    #1;
    check("abort_outputs_now", all_outs(), 64'h0);
    @(negedge clk);
    check("abort_outputs_held", all_outs(), 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    accept_word(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    wait_result(8'h01, 8'h01, 1'b0);

    // Back-to-back with in_valid held high.
    @(posedge clk); #1;
    in_a = 8'h80; in_b = 8'h80; in_cin = 1'b0; in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin seen = 1; break; end
    end
    check("b2b_first_accept", 64'(seen), 64'h1);
    sb.push_back({1'b1, 8'h00});
    @(posedge clk); #1;
    in_a = 8'h10; in_b = 8'h20;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin seen = 1; break; end
    end
    check("b2b_second_accept", 64'(seen), 64'h1);
    sb.push_back({1'b0, 8'h30});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_accept_gap", 64'(acc_cyc - hs_cyc), 64'h1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    check("b2b_second_result", 64'(seen), 64'h1);
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
